// File: rtl/irq_ctrl.sv
// Interrupt aggregation controller: synchronises raw requests, latches them as
// edge/level pending bits, masks with ENABLE and drives a registered HWInt vector.
module irq_ctrl #(
    parameter int NSRC        = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_irq,
    input  logic            sel,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [5:0]      HWInt,
    output logic            irq_any
);

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q;
    logic [NSRC-1:0] prev_q;
    logic [NSRC-1:0] enable_q,  enable_d;
    logic [NSRC-1:0] mode_q,    mode_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [5:0]      hwint_q,   hwint_d;
    logic            irq_any_q, irq_any_d;

    logic [NSRC-1:0] s;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] mode_chg;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] masked;
    logic [2:0]      first_idx;
    logic            wr;
    logic            unused_wdata;

    assign s            = sync_q[SYNC_STAGES-1];
    assign unused_wdata = ^wdata[31:NSRC];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        wr        = sel & we;
        enable_d  = enable_q;
        mode_d    = mode_q;
        mode_chg  = '0;
        w1c       = '0;
        hwint_d   = '0;
        first_idx = '0;

        if (wr && addr == ADDR_ENABLE) enable_d = wdata[NSRC-1:0];
        if (wr && addr == ADDR_MODE) begin
            mode_d   = wdata[NSRC-1:0];
            mode_chg = wdata[NSRC-1:0] ^ mode_q;
        end
        if (wr && addr == ADDR_PENDING) w1c = wdata[NSRC-1:0];

        // Edge sources: a new rising edge wins over a same-cycle clear.
        rise      = s & ~prev_q;
        pending_d = ((mode_q & (rise | (pending_q & ~w1c))) | (~mode_q & s)) & ~mode_chg;

        masked               = pending_q & enable_q;
        hwint_d[NSRC-1:0]    = masked;
        irq_any_d            = |masked;

        for (int i = NSRC - 1; i >= 0; i--) begin
            if (masked[i]) first_idx = 3'(i + 1);
        end
    end

    always_comb begin
        rdata = '0;
        if (sel && reset) begin
            case (addr)
                ADDR_ENABLE:  rdata[NSRC-1:0] = enable_q;
                ADDR_MODE:    rdata[NSRC-1:0] = mode_q;
                ADDR_PENDING: rdata[NSRC-1:0] = pending_q;
                ADDR_STATUS: begin
                    rdata[NSRC-1:0] = s;
                    rdata[10:8]     = first_idx;
                end
                default:      rdata = '0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, keeping the synchroniser a true chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            prev_q    <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            hwint_q   <= '0;
            irq_any_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], src_irq};
            prev_q    <= s;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            hwint_q   <= hwint_d;
            irq_any_q <= irq_any_d;
        end
    end

    assign HWInt   = hwint_q;
    assign irq_any = irq_any_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal expectations
// plus a randomized phase compared every cycle against a behavioural model.
module tb_irq_ctrl;

    localparam int NSRC = 6;
    localparam int SS   = 2;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [5:0]  src_irq = '0;
    logic        sel     = 1'b0;
    logic        we      = 1'b0;
    logic [1:0]  addr    = '0;
    logic [31:0] wdata   = '0;
    logic [31:0] rdata;
    logic [5:0]  HWInt;
    logic        irq_any;

    int n_checks = 0;
    int n_pass   = 0;

    irq_ctrl #(.NSRC(NSRC), .SYNC_STAGES(SS)) dut (
        .clk     (clk),
        .reset   (reset),
        .src_irq (src_irq),
        .sel     (sel),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .HWInt   (HWInt),
        .irq_any (irq_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [5:0] m_s = '0, m_prev = '0, m_en = '0, m_mode = '0, m_pend = '0, m_hw = '0;
    logic       m_any = 1'b0;
    logic [5:0] hist[$];

    always @(posedge clk or negedge reset) begin : model
        logic [5:0] new_pend;
        bit         w;
        if (!reset) begin
            m_s = '0; m_prev = '0; m_en = '0; m_mode = '0; m_pend = '0;
            m_hw = '0; m_any = 1'b0;
            hist.delete();
        end else begin
            w = sel && we;
            for (int i = 0; i < NSRC; i++) begin
                if (w && addr == 2'd1 && wdata[i] != m_mode[i])
                    new_pend[i] = 1'b0;
                else if (m_mode[i]) begin
                    if (m_s[i] && !m_prev[i])                    new_pend[i] = 1'b1;
                    else if (w && addr == 2'd2 && wdata[i])      new_pend[i] = 1'b0;
                    else                                         new_pend[i] = m_pend[i];
                end else
                    new_pend[i] = m_s[i];
            end
            m_hw  = m_pend & m_en;
            m_any = (m_hw != 0);
            if (w && addr == 2'd0) m_en   = wdata[5:0];
            if (w && addr == 2'd1) m_mode = wdata[5:0];
            m_pend = new_pend;
            // s after this edge is the raw value seen SS edges ago (oldest first)
            hist.push_back(src_irq);
            m_prev = m_s;
            m_s    = (hist.size() >= SS) ? hist[hist.size() - SS] : 6'h00;
        end
    end

    function automatic logic [31:0] exp_rdata();
        logic [31:0] r;
        logic [5:0]  mk;
        r  = '0;
        mk = m_pend & m_en;
        if (!sel || !reset) return 32'h0;
        case (addr)
            2'd0: r[5:0] = m_en;
            2'd1: r[5:0] = m_mode;
            2'd2: r[5:0] = m_pend;
            default: begin
                r[5:0] = m_s;
                for (int i = 5; i >= 0; i--) if (mk[i]) r[10:8] = 3'(i + 1);
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        check("model_hwint",   {26'b0, HWInt},   {26'b0, m_hw});
        check("model_irq_any", {31'b0, irq_any}, {31'b0, m_any});
        check("model_rdata",   rdata,            exp_rdata());
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    initial begin
        int b;
        src_irq = 6'h3F;
        #2 reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            tick();
            rd("reset_read", 2'(a), 32'h0);
        end
        check("reset_hwint", {26'b0, HWInt}, 32'h0);
        check("reset_any", {31'b0, irq_any}, 32'h0);
        sel = 1'b0;

        // release; ENABLE stays 0 so HWInt must not rise
        tick();
        reset = 1'b1;
        repeat (SS) tick();
        rd("release_status", 2'd3, 32'h3F);
        repeat (4) tick();
        check("release_hwint", {26'b0, HWInt}, 32'h0);
        src_irq = 6'h00;
        repeat (5) tick();

        // edge capture with exact latency
        wr(2'd0, 32'h04);
        wr(2'd1, 32'h04);
        repeat (3) tick();
        src_irq = 6'h04;
        tick(); tick();
        src_irq = 6'h00;
        tick();
        check("edge_lat_early", {26'b0, HWInt}, 32'h0);
        tick();
        check("edge_lat", {26'b0, HWInt}, 32'h04);
        repeat (4) tick();
        check("edge_hold", {26'b0, HWInt}, 32'h04);
        rd("edge_status", 2'd3, 32'h300);
        wr(2'd2, 32'h04);
        rd("w1c_pend", 2'd2, 32'h0);
        tick();
        check("w1c_hwint", {26'b0, HWInt}, 32'h0);

        // set/clear collision on the detect cycle
        tick(); tick();
        src_irq = 6'h04;
        tick(); tick();
        sel = 1'b1; we = 1'b1; addr = 2'd2; wdata = 32'h04;
        tick();
        we = 1'b0;
        rd("coll_pend", 2'd2, 32'h04);
        tick();
        check("coll_hwint", {26'b0, HWInt}, 32'h04);
        src_irq = 6'h00;
        repeat (4) tick();
        wr(2'd2, 32'h04);
        tick();

        // level mode
        wr(2'd1, 32'h00);
        wr(2'd0, 32'h01);
        src_irq = 6'h01;
        repeat (SS + 2) tick();
        check("lvl_hwint", {26'b0, HWInt}, 32'h01);
        wr(2'd2, 32'h01);
        tick();
        check("lvl_w1c_hwint", {26'b0, HWInt}, 32'h01);
        rd("lvl_w1c_pend", 2'd2, 32'h01);
        src_irq = 6'h00;
        repeat (SS + 1) tick();
        check("lvl_drop_early", {26'b0, HWInt}, 32'h01);
        tick();
        check("lvl_drop", {26'b0, HWInt}, 32'h0);

        // priority and mask
        wr(2'd0, 32'h3F);
        src_irq = 6'h28;
        repeat (5) tick();
        rd("prio_status", 2'd3, 32'h428);
        wr(2'd0, 32'h20);
        tick();
        check("mask_hwint", {26'b0, HWInt}, 32'h20);
        rd("mask_status", 2'd3, 32'h628);
        wr(2'd0, 32'h00);
        tick();
        check("mask_any", {31'b0, irq_any}, 32'h0);
        rd("mask_pend", 2'd2, 32'h28);
        src_irq = 6'h00;
        repeat (5) tick();

        // MODE change clears the pending bit on the write edge
        wr(2'd1, 32'h02);
        repeat (2) tick();
        src_irq = 6'h02;
        tick(); tick();
        src_irq = 6'h00;
        repeat (4) tick();
        rd("mc_pend_set", 2'd2, 32'h02);
        wr(2'd1, 32'h00);
        rd("mc_pend_clr", 2'd2, 32'h0);

        // randomized traffic, checked every cycle by the model
        for (int n = 0; n < 2000; n++) begin
            tick();
            sel   = ($urandom_range(0, 3) != 0);
            we    = ($urandom_range(0, 5) == 0);
            addr  = 2'($urandom_range(0, 3));
            wdata = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                b = $urandom_range(0, 5);
                src_irq[b] = ~src_irq[b];
            end
        end
        sel = 1'b0; we = 1'b0;
        tick();

        // asynchronous reset between clock edges
        wr(2'd1, 32'h00);
        wr(2'd0, 32'h3F);
        src_irq = 6'h3F;
        repeat (5) tick();
        check("pre_rst_any", {31'b0, irq_any}, 32'h1);
        src_irq = 6'h15;
        #2 reset = 1'b0;
        #1;
        check("async_hwint", {26'b0, HWInt}, 32'h0);
        check("async_any", {31'b0, irq_any}, 32'h0);
        tick();
        reset = 1'b1;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
